// File: rtl/instr_loader.sv
// Instruction loader: takes a length-prefixed little-endian byte stream and
// writes it word by word into instruction memory. The CPU is held in reset
// until the load completes.
module instr_loader #(
    parameter int                WIDTH     = 32,
    parameter int                MAX_WORDS = 1024,
    parameter logic [WIDTH-1:0]  BASE_ADDR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             cpu_rst,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_LAST = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [23:0]      word_q, word_d;     // first three bytes of the current group
    logic [31:0]      len_q, len_d;
    logic [31:0]      idx_q, idx_d;
    logic             wr_en_q, wr_en_d;
    logic [WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             cpu_rst_q, done_q, err_q;

    logic             acc;
    logic [31:0]      full;

    // Ready depends only on the state register, so no input-to-output path.
    assign byte_ready = (state_q == S_LEN) || (state_q == S_DATA);
    assign acc        = byte_valid && byte_ready;
    // Completed little-endian word when the 4th byte arrives this cycle.
    assign full       = {byte_data, word_q};

    // Next-state logic: byte assembly, header decode and write generation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        len_d     = len_q;
        idx_d     = idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (acc) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = {byte_data, word_q[23:8]};
        end

        case (state_q)
            S_LEN: begin
                if (acc && cnt_q == 2'd3) begin
                    len_d = full;
                    idx_d = '0;
                    if (full == 32'd0)
                        state_d = S_DONE;
                    else if (full > 32'(MAX_WORDS))
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (acc && cnt_q == 2'd3) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = BASE_ADDR + WIDTH'({idx_q[29:0], 2'b00});
                    wr_data_d = WIDTH'(full);
                    idx_d     = idx_q + 32'd1;
                    if (idx_q == len_q - 32'd1)
                        state_d = S_LAST;
                end
            end
            S_LAST:  state_d = S_DONE;
            default: state_d = state_q;   // DONE and ERR hold until reset
        endcase
    end

    // State and registered outputs; status flags follow the next state so
    // they change in the same cycle the FSM enters DONE/ERR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_LEN;
            cnt_q     <= '0;
            word_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= BASE_ADDR;
            wr_data_q <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cpu_rst_q <= (state_d != S_DONE);
            done_q    <= (state_d == S_DONE);
            err_q     <= (state_d == S_ERR);
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign cpu_rst = cpu_rst_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: expected writes go into a queue as words are sent;
// a negedge monitor pops and compares every write strobe.
module tb_instr_loader;

    localparam int MAXW = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_rst;
    logic        done;
    logic        err;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_chk = 0;
    int  n_err = 0;
    int  n_wr  = 0;
    bit  gap   = 1'b0;

    instr_loader dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Scoreboard side: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && wr_en) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", 64'(wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(e.a));
                chk("wr_data", 64'(wr_data), 64'(e.d));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", 64'(byte_ready), 64'd1);
    endtask

    // Present one byte and return 1ns after the edge that accepts it.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        if (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    // Expected write is queued before its bytes go out.
    task automatic send_data(input int idx, input logic [31:0] w);
        wr_t e;
        e.a = 32'(idx) << 2;
        e.d = w;
        exp_q.push_back(e);
        send_word(w);
    endtask

    // Two-word program followed by exact end-of-load timing checks.
    task automatic two_word_load();
        int w0;
        w0 = n_wr;
        send_word(32'd2);
        send_data(0, 32'h0050_0513);
        send_data(1, 32'h0010_0593);
        byte_valid = 1'b0;
        @(negedge clk);
        chk("last_wr_en", 64'(wr_en), 64'd1);
        chk("last_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("end_done", 64'(done), 64'd1);
        chk("end_cpu_rst", 64'(cpu_rst), 64'd0);
        chk("end_wr_en", 64'(wr_en), 64'd0);
        chk("end_ready", 64'(byte_ready), 64'd0);
        chk("two_wr_cnt", 64'(n_wr - w0), 64'd2);
        chk("two_q_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int w0;
        logic [31:0] v;

        // Back-to-back two-word load
        do_reset();
        gap = 1'b0;
        two_word_load();

        // Garbage after DONE is refused
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            #1;
            chk("post_done_ready", 64'(byte_ready), 64'd0);
            chk("post_done_done", 64'(done), 64'd1);
            chk("post_done_cpu", 64'(cpu_rst), 64'd0);
        end
        byte_valid = 1'b0;

        // Same load with byte_valid toggling every cycle
        do_reset();
        gap = 1'b1;
        two_word_load();
        gap = 1'b0;

        // Zero-length header
        do_reset();
        w0 = n_wr;
        send_word(32'd0);
        byte_valid = 1'b0;
        @(negedge clk);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_cpu_rst", 64'(cpu_rst), 64'd0);
        repeat (3) @(negedge clk);
        chk("zero_no_wr", 64'(n_wr - w0), 64'd0);

        // Oversized header goes to ERR and stays there
        do_reset();
        w0 = n_wr;
        send_word(32'(MAXW + 1));
        @(negedge clk);
        chk("err_flag", 64'(err), 64'd1);
        chk("err_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("err_ready", 64'(byte_ready), 64'd0);
        chk("err_done", 64'(done), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
        end
        byte_valid = 1'b0;
        @(negedge clk);
        chk("err_sticky", 64'(err), 64'd1);
        chk("err_no_wr", 64'(n_wr - w0), 64'd0);

        // Reset mid-word aborts, then a fresh one-word load
        do_reset();
        w0 = n_wr;
        send_word(32'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        do_reset();
        send_word(32'd1);
        send_data(0, 32'h1234_5678);
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_wr_cnt", 64'(n_wr - w0), 64'd1);
        chk("abort_done", 64'(done), 64'd1);
        chk("abort_q_empty", 64'(exp_q.size()), 64'd0);

        // Full capacity load, last write at top word
        do_reset();
        w0 = n_wr;
        send_word(32'(MAXW));
        for (int i = 0; i < MAXW; i++) begin
            v = {16'(i), ~16'(i)} ^ 32'hA5C3_0F96;
            send_data(i, v);
        end
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("full_wr_cnt", 64'(n_wr - w0), 64'(MAXW));
        chk("full_last_addr", 64'(wr_addr), 64'(4 * (MAXW - 1)));
        chk("full_done", 64'(done), 64'd1);
        chk("full_q_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter WIDTH, default 32: data and address width of the memory write port.
REQ-002 Parameter MAX_WORDS, default 1024: instruction memory capacity in 32-bit words.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first loaded word.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 byte_valid  input  1  upstream byte stream has a byte on byte_data.
REQ-007 byte_data  input  8  stream byte.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 wr_en  output  1  one-cycle instruction memory write strobe.
REQ-010 wr_addr  output  WIDTH  word-aligned byte address of the write.
REQ-011 wr_data  output  WIDTH  instruction word to write.
REQ-012 cpu_rst  output  1  active-high hold applied to the CPU reset input; 1 until load completes.
REQ-013 done  output  1  load completed successfully; sticky.
REQ-014 err  output  1  length header exceeded MAX_WORDS; sticky.

Function
REQ-015 A byte shall be accepted only in a cycle where byte_valid and byte_ready are both 1; byte_data is ignored otherwise.
REQ-016 Stream format: 4-byte little-endian word count N, then N words of 4 bytes each, little-endian (first byte = bits 7:0).
REQ-017 FSM states: LEN, DATA, LAST, DONE, ERR. byte_ready = 1 in LEN and DATA, 0 in LAST, DONE and ERR.
REQ-018 A 2-bit byte counter shall count accepted bytes within the current 4-byte group and wrap from 3 to 0.
REQ-019 LEN: on the 4th accepted byte, if N == 0 go to DONE; if N > MAX_WORDS go to ERR; otherwise go to DATA with word index 0.
REQ-020 DATA: on the 4th byte of a word that is not the last one, register wr_data = the assembled word, wr_addr = BASE_ADDR + 4*index and wr_en = 1 for exactly the next cycle, then increment the index; stay in DATA.
REQ-021 DATA: on the 4th byte of word N-1, perform the same registered write and go to LAST; wr_en is high during the LAST cycle.
REQ-022 LAST shall last exactly one cycle and then go to DONE.
REQ-023 DONE: done = 1, cpu_rst = 0, wr_en = 0, byte_ready = 0; remain in DONE until reset.
REQ-024 ERR: err = 1, cpu_rst = 1, wr_en = 0, byte_ready = 0; no memory writes; remain in ERR until reset.
REQ-025 done, err and cpu_rst shall be registered, with no combinational path from the inputs.
REQ-026 Back-to-back bytes (byte_valid held at 1) shall be accepted every cycle in LEN and DATA; a gap in byte_valid shall only stall, never corrupt, assembly.
REQ-027 N == MAX_WORDS is legal; the final write goes to BASE_ADDR + 4*(MAX_WORDS-1).

Reset
REQ-028 While rst = 0: state = LEN, byte counter = 0, index = 0, wr_en = 0, wr_addr = BASE_ADDR, wr_data = 0, cpu_rst = 1, done = 0, err = 0.
REQ-029 Reset asserted in the middle of a load shall abort it immediately, with no further wr_en; after release the loader waits for a new length header.
REQ-030 byte_ready shall be 1 in the first cycle after reset release.

Verification
REQ-031 Stream 02 00 00 00, 13 05 50 00, 93 05 10 00 sent back-to-back. Required: wr_en at 0x0 with 0x00500513, then at 0x4 with 0x00100593; done = 1 and cpu_rst = 0 one cycle after the second wr_en.
REQ-032 Stream 00 00 00 00. Required: no wr_en; done = 1 one cycle after the 4th byte; cpu_rst = 0.
REQ-033 Header with N = MAX_WORDS+1 (01 04 00 00 at the default). Required: err = 1, cpu_rst stays 1, byte_ready = 0, no wr_en, even if more bytes are offered.
REQ-034 Same stream as REQ-031 with byte_valid toggling 1/0 every cycle. Required: identical writes, addresses and final state.
REQ-035 rst pulled low after the 2nd data byte of word 0, then released and a fresh 1-word stream sent. Required: exactly one wr_en, at BASE_ADDR with the new word.
REQ-036 After done, byte_valid held at 1 with random data for 20 cycles. Required: byte_ready = 0, no wr_en, done and cpu_rst unchanged.
